// File: rtl/load_store_unit.sv
// Load/store unit: turns execute-stage byte accesses into word-indexed memory
// requests, stalls loads until the memory answers, and extends the result.
module load_store_unit #(
  parameter int unsigned MEM_AW  = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              rdata_valid,
  output logic              addr_fault,
  output logic              timeout_err,
  output logic              mem_request,
  output logic              mem_we_re,
  output logic              mem_load,
  output logic [3:0]        mem_mask,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_data_in,
  input  logic              mem_valid,
  input  logic [31:0]       mem_data_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic            flag_q, flag_d;
  logic [31:0]     rdata_d;

  logic        illegal, misaligned, fault;
  logic [31:0] byte_sh, half_sh, load_ext;

  // Upper address bits are intentionally outside the memory's reach.
  logic unused_addr;
  assign unused_addr = ^addr[31:MEM_AW+2];

  // Access legality
  always_comb begin
    illegal    = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
                 (lsu_we && ((funct3 == 3'b100) || (funct3 == 3'b101)));
    misaligned = (((funct3 == 3'b001) || (funct3 == 3'b101)) && addr[0]) ||
                 ((funct3 == 3'b010) && (addr[1:0] != 2'b00));
    fault      = lsu_req && (illegal || misaligned);
  end

  // Lane extraction from the returned word using the latched offset/width
  always_comb begin
    byte_sh = mem_data_out >> {off_q, 3'b000};
    half_sh = mem_data_out >> {off_q[1], 4'b0000};
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b100:  load_ext = {24'd0, byte_sh[7:0]};
      3'b001:  load_ext = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b101:  load_ext = {16'd0, half_sh[15:0]};
      default: load_ext = mem_data_out;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      f3_q   <= 3'd0;
      off_q  <= 2'd0;
      flag_q <= 1'b0;
      rdata  <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      f3_q   <= f3_d;
      off_q  <= off_d;
      flag_q <= flag_d;
      rdata  <= rdata_d;
    end
  end

  // Next state, request decode and datapath updates
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    off_d       = off_q;
    flag_d      = flag_q;
    rdata_d     = rdata;
    stall       = 1'b0;
    addr_fault  = 1'b0;
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_load    = 1'b0;
    mem_mask    = 4'b0000;
    mem_address = '0;
    mem_data_in = 32'd0;

    case (state)
      S_IDLE: begin
        if (fault) begin
          addr_fault = 1'b1;
        end else if (lsu_req) begin
          mem_request = 1'b1;
          mem_address = addr[MEM_AW+1:2];
          if (lsu_we) begin
            mem_we_re = 1'b1;
            case (funct3)
              3'b000: begin
                mem_mask    = 4'b0001 << addr[1:0];
                mem_data_in = {4{wdata[7:0]}};
              end
              3'b001: begin
                mem_mask    = addr[1] ? 4'b1100 : 4'b0011;
                mem_data_in = {2{wdata[15:0]}};
              end
              default: begin
                mem_mask    = 4'b1111;
                mem_data_in = wdata;
              end
            endcase
          end else begin
            mem_load = 1'b1;
            mem_mask = 4'b1111;
            stall    = 1'b1;
            f3_d     = funct3;
            off_d    = addr[1:0];
            cnt_d    = '0;
            state_d  = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (mem_valid) begin
          rdata_d = load_ext;
          flag_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
          if (cnt_q == TO_W'(TIMEOUT - 1)) begin
            rdata_d = 32'd0;
            flag_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Requests must not leak out while reset is held
    if (!rst) begin
      stall       = 1'b0;
      addr_fault  = 1'b0;
      mem_request = 1'b0;
      mem_we_re   = 1'b0;
      mem_load    = 1'b0;
      mem_mask    = 4'b0000;
      mem_address = '0;
      mem_data_in = 32'd0;
    end
  end

  assign rdata_valid = (state == S_DONE);
  assign timeout_err = (state == S_DONE) && flag_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and the data memory top block, and owns every data-memory access of the core.
- Converts load/store requests (byte address, RISC-V funct3 width) into word-indexed memory requests with byte masks and replicated write data.
- On loads, stalls the pipeline until the memory's valid pulse, then extracts the addressed byte/halfword/word and sign- or zero-extends it.
- Rejects misaligned or illegal-width accesses, and times out a load whose valid never arrives.

Parameters:
MEM_AW, 8, word-address width driven to memory (mem_address = addr[MEM_AW+1:2])
TIMEOUT, 15, max cycles spent in WAIT before declaring a timeout (1..2^TO_W-1)
TO_W, 4, width of the timeout counter

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous active-low reset
lsu_req  in  1  access request from execute; held high while stall=1
lsu_we  in  1  1=store, 0=load
funct3  in  3  width: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
addr  in  32  effective byte address
wdata  in  32  store data (low bits used)
stall  out  1  freeze pipeline
rdata  out  32  extended load result (registered)
rdata_valid  out  1  rdata valid for this cycle (DONE state)
addr_fault  out  1  misaligned/illegal access rejected (combinational, IDLE only)
timeout_err  out  1  load timed out (DONE state only)
mem_request  out  1  to memory request
mem_we_re  out  1  to memory we_re (1=write)
mem_load  out  1  to memory load (drives its valid)
mem_mask  out  4  byte mask
mem_address  out  MEM_AW  word address
mem_data_in  out  32  replicated write data
mem_valid  in  1  memory valid (rises one cycle after mem_load)
mem_data_out  in  32  memory read word

Behaviour:
Reset (rst=0, asynchronous) is the same at power-up and mid-operation:
- State=IDLE; timeout counter=0; rdata=0.
- All outputs 0, including stall, rdata_valid, timeout_err, addr_fault and every mem_* output.
- Any outstanding load is abandoned.

FSM states: IDLE, WAIT, DONE.

Fault check:
- fault = lsu_req & (illegal funct3 | misaligned).
- Illegal funct3: 011, 110, 111; 100 and 101 are also illegal when lsu_we=1.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.

IDLE:
- Fault: addr_fault=1 this cycle, no mem_request, no stall, stay in IDLE.
- Legal store: same cycle, mem_request=1, mem_we_re=1, mem_load=0, mask and data per the rules below. Completes in one cycle; stall=0; stay in IDLE.
- Legal load: same cycle, mem_request=1, mem_we_re=0, mem_load=1, mem_mask=1111, stall=1.
  - Latch funct3 and addr[1:0]; clear the counter; go to WAIT.

WAIT:
- All mem_* outputs 0; stall=1; lsu_req ignored.
- mem_valid=1: register the extracted mem_data_out into rdata, timeout_err flag <= 0, go to DONE.
- Otherwise increment the counter. When the counter reaches TIMEOUT: rdata <= 0, timeout flag <= 1, go to DONE.

DONE (exactly one cycle):
- stall=0, rdata_valid=1, timeout_err=flag.
- lsu_req is ignored: it still reflects the completed load; this prevents a re-issue.
- Next state is IDLE.

Store mask and data (o = addr[1:0]):
- SB: mask = 0001<<o; data = {4{wdata[7:0]}}.
- SH: mask = 0011<<(2*addr[1]); data = {2{wdata[15:0]}}.
- SW: mask = 1111; data = wdata.

Load extraction (o = latched offset):
- B/BU: byte mem_data_out[8o+7:8o], sign-/zero-extended.
- H/HU: half mem_data_out[16*o[1]+15:16*o[1]], sign-/zero-extended.
- W: full word.

Other rules:
- mem_address = addr[MEM_AW+1:2]; upper address bits are ignored (no fault).
- A mem_valid seen in IDLE or DONE is ignored.
- Load-use latency: issue in cycle N, mem_valid in N+1, rdata_valid in N+2. The pipeline is stalled in cycles N and N+1.

Test Plan:
- Reset then SW addr=0x0000_0010, wdata=0xDEADBEEF -> same cycle mem_request=1, we_re=1, mask=1111, mem_address=0x04, mem_data_in=0xDEADBEEF, stall=0.
- SB addr=0x13 wdata=0xAB -> mask=1000, mem_data_in=0xABABABAB, address=0x04.
- SH addr=0x12 wdata=0x1234 -> mask=1100, mem_data_in=0x12341234.
- LB addr=0x13 with mem_data_out=0x80FF_0000, mem_valid one cycle after issue:
  - stall=1 for 2 cycles;
  - DONE: rdata=0xFFFF_FF80, rdata_valid=1.
- LBU on the same word -> rdata=0x0000_0080. LHU addr=0x12 -> 0x0000_80FF.
- LW addr=0x12 -> addr_fault=1, no mem_request, stall=0. funct3=011 -> addr_fault=1.
- LW with mem_valid never asserted:
  - stall held for 1+TIMEOUT cycles;
  - then one DONE cycle with timeout_err=1, rdata=0;
  - lsu_req still high in DONE causes no re-issue.
- Assert rst=0 mid-WAIT -> stall, mem_* and rdata_valid drop immediately; after release the FSM is in IDLE and a fresh LW completes normally.
